// File: rtl/led_panel_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : led_panel_driver                                                  |
// | Desc   : Per-channel OFF/ON/BLINK/BREATHE LED modes with shared PWM        |
// |          brightness. Optional macro LED_SEL_IND_EN: dim cursor on the      |
// |          selected channel while it is OFF.                                 |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module led_panel_driver #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BLINK_MS   = 250,
  parameter int BREATHE_MS = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] evt_pos,
  output logic [7:0] led,
  output logic [2:0] sel_ch,
  output logic [1:0] sel_mode,
  output logic [3:0] bright
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int c_MS_DIV = CLK_FREQ / 1000;
  localparam int c_MS_W   = (c_MS_DIV   > 1) ? $clog2(c_MS_DIV)   : 1;
  localparam int c_BL_W   = (BLINK_MS   > 1) ? $clog2(BLINK_MS)   : 1;
  localparam int c_BR_W   = (BREATHE_MS > 1) ? $clog2(BREATHE_MS) : 1;
  localparam logic [c_MS_W-1:0] c_MS_LAST = c_MS_W'(c_MS_DIV - 1);
  localparam logic [c_BL_W-1:0] c_BL_LAST = c_BL_W'(BLINK_MS - 1);
  localparam logic [c_BR_W-1:0] c_BR_LAST = c_BR_W'(BREATHE_MS - 1);

  logic [c_MS_W-1:0] r_ms_cnt;
  logic [c_BL_W-1:0] r_blink_cnt;
  logic              r_blink_phase;
  logic [c_BR_W-1:0] r_br_cnt;
  logic [3:0]        r_br_level;
  logic              r_br_down;
  logic [3:0]        r_pwm_cnt;
  logic [2:0]        r_sel_ch;
  logic [3:0]        r_bright;
  mode_t             r_mode [8];
  logic [7:0]        r_led;

  logic       w_ms_tick;
  logic       w_evt_mode, w_evt_sel, w_evt_up, w_evt_dn;
  logic [3:0] w_breathe_duty;
  logic [3:0] w_duty [8];
  logic [7:0] w_lit;

  assign w_ms_tick = (r_ms_cnt == c_MS_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ms_cnt      <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_br_cnt      <= '0;
      r_br_level    <= 4'd0;
      r_br_down     <= 1'b0;
      r_pwm_cnt     <= 4'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      r_ms_cnt  <= w_ms_tick ? '0 : r_ms_cnt + c_MS_W'(1);
      if (w_ms_tick) begin
        if (r_blink_cnt == c_BL_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_BL_W'(1);
        end
        // Direction flips on arrival at an end point, giving 0..15..0 triangle
        if (r_br_cnt == c_BR_LAST) begin
          r_br_cnt <= '0;
          if (!r_br_down) begin
            r_br_level <= r_br_level + 4'd1;
            if (r_br_level == 4'd14) r_br_down <= 1'b1;
          end else begin
            r_br_level <= r_br_level - 4'd1;
            if (r_br_level == 4'd1) r_br_down <= 1'b0;
          end
        end else begin
          r_br_cnt <= r_br_cnt + c_BR_W'(1);
        end
      end
    end
  end

  // Lowest set bit wins when several events arrive together
  always_comb begin
    w_evt_mode = 1'b0;
    w_evt_sel  = 1'b0;
    w_evt_up   = 1'b0;
    w_evt_dn   = 1'b0;
    if (evt_pos[0])      w_evt_mode = 1'b1;
    else if (evt_pos[1]) w_evt_sel  = 1'b1;
    else if (evt_pos[2]) w_evt_up   = 1'b1;
    else if (evt_pos[3]) w_evt_dn   = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sel_ch <= 3'd0;
      r_bright <= 4'd15;
      for (int i = 0; i < 8; i++) r_mode[i] <= MODE_OFF;
    end else begin
      if (w_evt_mode) r_mode[r_sel_ch] <= mode_t'(r_mode[r_sel_ch] + 2'd1);
      if (w_evt_sel)  r_sel_ch <= r_sel_ch + 3'd1;
      if (w_evt_up && r_bright != 4'd15) r_bright <= r_bright + 4'd1;
      if (w_evt_dn && r_bright != 4'd0)  r_bright <= r_bright - 4'd1;
    end
  end

  assign w_breathe_duty = (r_br_level < r_bright) ? r_br_level : r_bright;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_duty[i] = 4'd0;
      case (r_mode[i])
        MODE_ON:      w_duty[i] = r_bright;
        MODE_BLINK:   w_duty[i] = r_blink_phase ? r_bright : 4'd0;
        MODE_BREATHE: w_duty[i] = w_breathe_duty;
        default: begin
`ifdef LED_SEL_IND_EN
          if (r_sel_ch == 3'(i)) w_duty[i] = 4'd1;
`endif
        end
      endcase
      w_lit[i] = (r_pwm_cnt < w_duty[i]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_led <= 8'hFF;
    else            r_led <= ~w_lit;
  end

  assign led      = r_led;
  assign sel_ch   = r_sel_ch;
  assign sel_mode = r_mode[r_sel_ch];
  assign bright   = r_bright;

endmodule
`default_nettype wire

// File: tb/tb_led_panel_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_led_panel_driver                                               |
// | Desc   : Directed self-checking bench for led_panel_driver                 |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_led_panel_driver;

  localparam int c_CLK_FREQ   = 16000;
  localparam int c_BLINK_MS   = 2;
  localparam int c_BREATHE_MS = 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] evt_pos = 4'd0;
  logic [7:0] led;
  logic [2:0] sel_ch;
  logic [1:0] sel_mode;
  logic [3:0] bright;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  led_panel_driver #(
    .CLK_FREQ   (c_CLK_FREQ),
    .BLINK_MS   (c_BLINK_MS),
    .BREATHE_MS (c_BREATHE_MS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .evt_pos   (evt_pos),
    .led       (led),
    .sel_ch    (sel_ch),
    .sel_mode  (sel_mode),
    .bright    (bright)
  );

  always #5 sys_clk = ~sys_clk;

  // Clock edges since reset release; ms tick, PWM wrap and blink toggle align to it
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] e);
    @(negedge sys_clk);
    evt_pos = e;
    @(negedge sys_clk);
    evt_pos = 4'd0;
  endtask

  task automatic align(input int period);
    for (int i = 0; i < period; i++) begin
      if (cyc % period == 0) break;
      @(negedge sys_clk);
    end
  endtask

  task automatic measure(input int len, output int lows0, output int others_bad);
    lows0 = 0;
    others_bad = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge sys_clk);
      if (!led[0]) lows0++;
      if (led[7:1] != 7'h7F) others_bad++;
    end
  endtask

  function automatic int tri_level(input int m);
    int r;
    r = m % 30;
    return (r <= 15) ? r : 30 - r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows, bad, m, j, exp_lows, cap;

    // Reset and idle
    repeat (3) @(negedge sys_clk);
    check("rst_led", 32'(led), 32'hFF);
    check("rst_bright", 32'(bright), 32'd15);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      check("idle_led", 32'(led), 32'hFF);
      check("idle_sel_ch", 32'(sel_ch), 32'd0);
      check("idle_sel_mode", 32'(sel_mode), 32'd0);
      check("idle_bright", 32'(bright), 32'd15);
    end

    // Channel 0 ON at full brightness
    pulse(4'b0001);
    check("on_mode", 32'(sel_mode), 32'd1);
    measure(32, lows, bad);
    check("on_lows", 32'(lows), 32'd30);
    check("on_others", 32'(bad), 32'd0);

    // Channel select wraps, arbitration picks lowest bit
    for (int i = 1; i <= 8; i++) begin
      pulse(4'b0010);
      check("sel_step", 32'(sel_ch), 32'(i % 8));
    end
    check("sel_back_mode", 32'(sel_mode), 32'd1);
    pulse(4'b1010);
    check("arb_sel_ch", 32'(sel_ch), 32'd1);
    check("arb_bright", 32'(bright), 32'd15);
    check("arb_mode", 32'(sel_mode), 32'd0);

    // Dim to saturation, then brighten
    repeat (20) pulse(4'b1000);
    check("dim_sat", 32'(bright), 32'd0);
    measure(16, lows, bad);
    check("dark_lows", 32'(lows), 32'd0);
    check("dark_others", 32'(bad), 32'd0);
    pulse(4'b0100);
    check("up_one", 32'(bright), 32'd1);
    measure(16, lows, bad);
    check("dim1_lows", 32'(lows), 32'd1);
    check("dim1_others", 32'(bad), 32'd0);
    pulse(4'b1100);
    check("arb_up", 32'(bright), 32'd2);

    // Back to channel 0, full brightness, BLINK
    repeat (7) pulse(4'b0010);
    check("sel_ch0", 32'(sel_ch), 32'd0);
    repeat (14) pulse(4'b0100);
    check("up_sat", 32'(bright), 32'd15);
    pulse(4'b0001);
    check("blink_mode", 32'(sel_mode), 32'd2);
    align(32);
    for (int b = 0; b < 4; b++) begin
      j = cyc / 32;
      measure(32, lows, bad);
      check("blink_lows", 32'(lows), (j % 2) ? 32'd30 : 32'd0);
      check("blink_others", 32'(bad), 32'd0);
    end

    // Async reset mid-pattern
    pulse(4'b1000);
    pulse(4'b0010);
    check("pre_rst_bright", 32'(bright), 32'd14);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_led", 32'(led), 32'hFF);
    check("async_mode", 32'(sel_mode), 32'd0);
    check("async_sel", 32'(sel_ch), 32'd0);
    check("async_bright", 32'(bright), 32'd15);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    pulse(4'b0000);
    check("post_rst_mode", 32'(sel_mode), 32'd0);

    // BREATHE at two brightness caps
    repeat (3) pulse(4'b0001);
    check("breathe_mode", 32'(sel_mode), 32'd3);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        repeat (7) pulse(4'b1000);
        check("cap_bright", 32'(bright), 32'd8);
      end
      cap = (pass == 0) ? 15 : 8;
      align(16);
      for (int w = 0; w < 32; w++) begin
        m = cyc / 16;
        exp_lows = (tri_level(m) < cap) ? tri_level(m) : cap;
        measure(16, lows, bad);
        check("breathe_lows", 32'(lows), 32'(exp_lows));
        check("breathe_others", 32'(bad), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
